decode: RTL and testbench

Instruction decode stage of the 16-bit CPU pipeline, between FETCH (upstream) and EXECUTE (downstream). Accepts instruction words with their addresses from FETCH over a valid/ready handshake and splits each instruction into opcode and operand fields. For a two-word instruction it collects the trailing immediate word before issuing. It also drives the program-counter redirect port back into FETCH, both after reset and when EXECUTE reports a taken jump.

---
 rtl/decode.sv | 150 +++++++++++++++
 tb/tb_decode.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// Decode stage of the 16-bit pipeline. It splits FETCH words into operand fields,
// collects the trailing immediate of two-word instructions, and redirects FETCH.
module decode #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        fe_valid_i,
    output logic        fe_ready_o,
    input  logic [15:0] fe_addr_i,
    input  logic [15:0] fe_inst_i,
    output logic        fe_valid_o,
    output logic [15:0] fe_pc_o,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [15:0] ex_pc_o,
    output logic [3:0]  ex_opcode_o,
    output logic [3:0]  ex_src_reg_o,
    output logic [1:0]  ex_src_mode_o,
    output logic [3:0]  ex_dst_reg_o,
    output logic [1:0]  ex_dst_mode_o,
    output logic        ex_imm_valid_o,
    output logic [15:0] ex_imm_o,
    input  logic        ex_jump_i,
    input  logic [15:0] ex_jump_pc_i
);

    typedef enum logic [0:0] {
        S_OPC = 1'b0,
        S_IMM = 1'b1
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [15:0] hold_pc_r, hold_pc_nxt_s;
    logic [15:0] hold_inst_r, hold_inst_nxt_s;
    logic        ex_valid_r, ex_valid_nxt_s;
    logic [15:0] ex_pc_r, ex_pc_nxt_s;
    logic [15:0] ex_inst_r, ex_inst_nxt_s;
    logic        ex_imm_valid_r, ex_imm_valid_nxt_s;
    logic [15:0] ex_imm_r, ex_imm_nxt_s;
    logic        fe_valid_r, fe_valid_nxt_s;
    logic [15:0] fe_pc_r, fe_pc_nxt_s;
    logic        free_s;
    logic        accept_s;

    // A source operand of register F in mode 2 means an immediate word follows.
    function automatic logic is_two_word(input logic [15:0] word);
        return (word[11:8] == 4'hF) && (word[7:6] == 2'b10);
    endfunction

    assign free_s     = ~ex_valid_r | ex_ready_i;
    assign fe_ready_o = free_s & ~ex_jump_i & ~fe_valid_r;
    assign accept_s   = fe_valid_i & fe_ready_o;

    // Next-state logic for the decode FSM, output register and redirect port.
    always_comb begin
        state_nxt_s        = state_r;
        hold_pc_nxt_s      = hold_pc_r;
        hold_inst_nxt_s    = hold_inst_r;
        ex_valid_nxt_s     = ex_valid_r;
        ex_pc_nxt_s        = ex_pc_r;
        ex_inst_nxt_s      = ex_inst_r;
        ex_imm_valid_nxt_s = ex_imm_valid_r;
        ex_imm_nxt_s       = ex_imm_r;
        fe_valid_nxt_s     = 1'b0;
        fe_pc_nxt_s        = fe_pc_r;
        if (ex_jump_i) begin
            ex_valid_nxt_s = 1'b0;
            state_nxt_s    = S_OPC;
            fe_valid_nxt_s = 1'b1;
            fe_pc_nxt_s    = ex_jump_pc_i;
        end else begin
            if (ex_ready_i) begin
                ex_valid_nxt_s = 1'b0;
            end else begin
                ex_valid_nxt_s = ex_valid_r;
            end
            if (accept_s) begin
                case (state_r)
                    S_OPC: begin
                        if (is_two_word(fe_inst_i)) begin
                            hold_pc_nxt_s   = fe_addr_i;
                            hold_inst_nxt_s = fe_inst_i;
                            state_nxt_s     = S_IMM;
                        end else begin
                            ex_valid_nxt_s     = 1'b1;
                            ex_pc_nxt_s        = fe_addr_i;
                            ex_inst_nxt_s      = fe_inst_i;
                            ex_imm_valid_nxt_s = 1'b0;
                            ex_imm_nxt_s       = 16'h0000;
                        end
                    end
                    S_IMM: begin
                        ex_valid_nxt_s     = 1'b1;
                        ex_pc_nxt_s        = hold_pc_r;
                        ex_inst_nxt_s      = hold_inst_r;
                        ex_imm_valid_nxt_s = 1'b1;
                        ex_imm_nxt_s       = fe_inst_i;
                        state_nxt_s        = S_OPC;
                    end
                    default: begin
                        state_nxt_s = S_OPC;
                    end
                endcase
            end else begin
                state_nxt_s = state_r;
            end
        end
    end

    // State, hold, output and redirect registers; reset requests a fetch from RESET_PC.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r        <= S_OPC;
            hold_pc_r      <= 16'h0000;
            hold_inst_r    <= 16'h0000;
            ex_valid_r     <= 1'b0;
            ex_pc_r        <= 16'h0000;
            ex_inst_r      <= 16'h0000;
            ex_imm_valid_r <= 1'b0;
            ex_imm_r       <= 16'h0000;
            fe_valid_r     <= 1'b1;
            fe_pc_r        <= RESET_PC;
        end else begin
            state_r        <= state_nxt_s;
            hold_pc_r      <= hold_pc_nxt_s;
            hold_inst_r    <= hold_inst_nxt_s;
            ex_valid_r     <= ex_valid_nxt_s;
            ex_pc_r        <= ex_pc_nxt_s;
            ex_inst_r      <= ex_inst_nxt_s;
            ex_imm_valid_r <= ex_imm_valid_nxt_s;
            ex_imm_r       <= ex_imm_nxt_s;
            fe_valid_r     <= fe_valid_nxt_s;
            fe_pc_r        <= fe_pc_nxt_s;
        end
    end

    assign fe_valid_o     = fe_valid_r;
    assign fe_pc_o        = fe_pc_r;
    assign ex_valid_o     = ex_valid_r;
    assign ex_pc_o        = ex_pc_r;
    assign ex_opcode_o    = ex_inst_r[15:12];
    assign ex_src_reg_o   = ex_inst_r[11:8];
    assign ex_src_mode_o  = ex_inst_r[7:6];
    assign ex_dst_reg_o   = ex_inst_r[5:2];
    assign ex_dst_mode_o  = ex_inst_r[1:0];
    assign ex_imm_valid_o = ex_imm_valid_r;
    assign ex_imm_o       = ex_imm_r;

endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the stage.
module tb_decode;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        fe_valid_i = 1'b0;
    logic        fe_ready_o;
    logic [15:0] fe_addr_i = 16'h0000;
    logic [15:0] fe_inst_i = 16'h0000;
    logic        fe_valid_o;
    logic [15:0] fe_pc_o;
    logic        ex_valid_o;
    logic        ex_ready_i = 1'b1;
    logic [15:0] ex_pc_o;
    logic [3:0]  ex_opcode_o;
    logic [3:0]  ex_src_reg_o;
    logic [1:0]  ex_src_mode_o;
    logic [3:0]  ex_dst_reg_o;
    logic [1:0]  ex_dst_mode_o;
    logic        ex_imm_valid_o;
    logic [15:0] ex_imm_o;
    logic        ex_jump_i = 1'b0;
    logic [15:0] ex_jump_pc_i = 16'h0000;

    decode #(.RESET_PC(16'h0100)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .fe_valid_i(fe_valid_i), .fe_ready_o(fe_ready_o),
        .fe_addr_i(fe_addr_i), .fe_inst_i(fe_inst_i),
        .fe_valid_o(fe_valid_o), .fe_pc_o(fe_pc_o),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_pc_o(ex_pc_o), .ex_opcode_o(ex_opcode_o),
        .ex_src_reg_o(ex_src_reg_o), .ex_src_mode_o(ex_src_mode_o),
        .ex_dst_reg_o(ex_dst_reg_o), .ex_dst_mode_o(ex_dst_mode_o),
        .ex_imm_valid_o(ex_imm_valid_o), .ex_imm_o(ex_imm_o),
        .ex_jump_i(ex_jump_i), .ex_jump_pc_i(ex_jump_pc_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int fails = 0;
    int ex_pulses = 0;
    bit cmp_en = 1'b0;

    // Model: the pending redirect, the issued instruction (as a whole word) and a pending first word.
    bit          m_fe_valid;
    logic [15:0] m_fe_pc;
    bit          m_ex_valid;
    logic [15:0] m_ex_pc, m_ex_inst, m_ex_imm;
    bit          m_ex_immv;
    bit          m_pend;
    logic [15:0] m_pend_pc, m_pend_inst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit needs_imm(input logic [15:0] w);
        return ((w >> 8) & 16'h000F) == 16'h000F && ((w >> 6) & 16'h0003) == 16'h0002;
    endfunction

    function automatic bit model_ready();
        return (!m_ex_valid || ex_ready_i) && !ex_jump_i && !m_fe_valid;
    endfunction

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            m_fe_valid = 1'b1; m_fe_pc = 16'h0100;
            m_ex_valid = 1'b0; m_ex_pc = 16'h0000; m_ex_inst = 16'h0000;
            m_ex_imm = 16'h0000; m_ex_immv = 1'b0; m_pend = 1'b0;
            m_pend_pc = 16'h0000; m_pend_inst = 16'h0000;
        end else begin
            automatic bit take = fe_valid_i && model_ready();
            automatic bit consumed = !m_ex_valid || ex_ready_i;
            m_fe_valid = ex_jump_i;
            if (ex_jump_i) begin
                m_fe_pc = ex_jump_pc_i;
                m_ex_valid = 1'b0;
                m_pend = 1'b0;
            end else begin
                if (consumed) m_ex_valid = 1'b0;
                if (take && m_pend) begin
                    m_ex_valid = 1'b1; m_ex_pc = m_pend_pc; m_ex_inst = m_pend_inst;
                    m_ex_immv = 1'b1; m_ex_imm = fe_inst_i; m_pend = 1'b0;
                end else if (take && needs_imm(fe_inst_i)) begin
                    m_pend = 1'b1; m_pend_pc = fe_addr_i; m_pend_inst = fe_inst_i;
                end else if (take) begin
                    m_ex_valid = 1'b1; m_ex_pc = fe_addr_i; m_ex_inst = fe_inst_i;
                    m_ex_immv = 1'b0; m_ex_imm = 16'h0000;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (ex_valid_o === 1'b1) ex_pulses++;
        if (cmp_en) begin
            chk("fe_valid", fe_valid_o, m_fe_valid);
            chk("fe_pc", fe_pc_o, m_fe_pc);
            chk("ex_valid", ex_valid_o, m_ex_valid);
            chk("fe_ready", fe_ready_o, rstn_i ? model_ready() : 1'b0);
            if (m_ex_valid) begin
                chk("ex_pc", ex_pc_o, m_ex_pc);
                chk("ex_fields", {ex_opcode_o, ex_src_reg_o, ex_src_mode_o, ex_dst_reg_o, ex_dst_mode_o}, m_ex_inst);
                chk("ex_immv", ex_imm_valid_o, m_ex_immv);
                chk("ex_imm", ex_imm_o, m_ex_imm);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic word(input logic [15:0] a, input logic [15:0] w);
        fe_valid_i = 1'b1; fe_addr_i = a; fe_inst_i = w;
    endtask

    initial begin
        int p0;
        logic [31:0] r;
        step(); step();
        cmp_en = 1'b1;
        chk("rst_ex_valid", ex_valid_o, 1'b0);
        chk("rst_ex_data", {ex_pc_o, ex_imm_o}, 32'h0);
        // Reset release: redirect to 0x0100 visible for exactly one cycle.
        rstn_i = 1'b1;
        #3;
        chk("rel_fe_valid", fe_valid_o, 1'b1);
        chk("rel_fe_pc", fe_pc_o, 16'h0100);
        step();
        chk("rel_fe_valid_fall", fe_valid_o, 1'b0);
        // Single-word back-to-back stream.
        word(16'h0100, 16'h1234);
        step();
        word(16'h0101, 16'h5678);
        chk("sw1_fields", {ex_valid_o, ex_opcode_o, ex_src_reg_o, ex_src_mode_o, ex_dst_reg_o, ex_dst_mode_o},
            {1'b1, 4'h1, 4'h2, 2'd0, 4'hD, 2'd0});
        chk("sw1_pc", ex_pc_o, 16'h0100);
        chk("sw1_immv", ex_imm_valid_o, 1'b0);
        step();
        fe_valid_i = 1'b0;
        chk("sw2_pc_op", {ex_valid_o, ex_pc_o, ex_opcode_o}, {1'b1, 16'h0101, 4'h5});
        chk("sw2_immv", ex_imm_valid_o, 1'b0);
        step();
        // Two-word instruction.
        p0 = ex_pulses;
        word(16'h0200, 16'h0F80);
        step();
        word(16'h0201, 16'hBEEF);
        step();
        fe_valid_i = 1'b0;
        chk("imm_issue", {ex_valid_o, ex_pc_o, ex_src_reg_o, ex_src_mode_o}, {1'b1, 16'h0200, 4'hF, 2'd2});
        chk("imm_word", {ex_imm_valid_o, ex_imm_o}, {1'b1, 16'hBEEF});
        step(); step();
        chk("imm_pulses", ex_pulses - p0, 1);
        // Backpressure: entry held five cycles, FETCH stalled.
        word(16'h0300, 16'h2345);
        step();
        ex_ready_i = 1'b0;
        word(16'h0301, 16'h3456);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready", fe_ready_o, 1'b0);
            chk("bp_hold", {ex_valid_o, ex_pc_o, ex_opcode_o, ex_dst_reg_o, ex_imm_valid_o}, {1'b1, 16'h0300, 4'h2, 4'h1, 1'b0});
            step();
        end
        ex_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", fe_ready_o, 1'b1);
        step();
        fe_valid_i = 1'b0;
        chk("bp_next", {ex_valid_o, ex_pc_o, ex_opcode_o}, {1'b1, 16'h0301, 4'h3});
        step();
        // Jump while a two-word instruction is waiting for its immediate.
        word(16'h0400, 16'h0F80);
        step();
        word(16'h0401, 16'hAAAA);
        ex_jump_i = 1'b1; ex_jump_pc_i = 16'h0300;
        #1;
        chk("jmp_ready", fe_ready_o, 1'b0);
        step();
        ex_jump_i = 1'b0;
        chk("jmp_redirect", {ex_valid_o, fe_valid_o, fe_pc_o}, {1'b0, 1'b1, 16'h0300});
        #1;
        chk("jmp_ready2", fe_ready_o, 1'b0);
        step();
        chk("jmp_no_issue", ex_valid_o, 1'b0);
        step();
        fe_valid_i = 1'b0;
        chk("jmp_fresh", {ex_valid_o, ex_pc_o, ex_opcode_o, ex_imm_valid_o}, {1'b1, 16'h0401, 4'hA, 1'b0});
        // Asynchronous reset while an entry is stalled.
        word(16'h0500, 16'h7001);
        step();
        fe_valid_i = 1'b0; ex_ready_i = 1'b0;
        step();
        #2;
        rstn_i = 1'b0;
        #1;
        chk("arst_ex_valid", ex_valid_o, 1'b0);
        chk("arst_fe", {fe_valid_o, fe_pc_o}, {1'b1, 16'h0100});
        step();
        rstn_i = 1'b1; ex_ready_i = 1'b1;
        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            fe_valid_i = ($urandom_range(0, 3) != 0);
            fe_addr_i = fe_addr_i + 16'h0001;
            if ($urandom_range(0, 2) == 0)
                fe_inst_i = {r[15:12], 4'hF, 2'b10, r[5:0]};
            else
                fe_inst_i = r[15:0];
            ex_ready_i = ($urandom_range(0, 3) != 0);
            ex_jump_i = ($urandom_range(0, 19) == 0);
            ex_jump_pc_i = r[31:16];
            step();
        end
        fe_valid_i = 1'b0; ex_jump_i = 1'b0;
        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
